// File: rtl/dma_burst_sram.sv
// -----------------------------------------------------------------------------
// dma_burst_sram
//
// Single-port SRAM with a burst DMA front end. One command describes a burst
// of 1..256 consecutive words. A write burst takes beats from the
// wvalid/wready channel with per-byte enables, and the writer may stall.
// A read burst issues one read per cycle without stalls and returns the
// beats RD_LAT cycles later on rvalid/rdata, with rlast on the final beat.
// Addresses wrap from DEPTH-1 to 0. A burst whose start address is DEPTH or
// above runs the normal handshake but never writes, reads back zeros, and
// reports err together with its done pulse.
//
// Ports
//   CK, RSTN                 clock (rising edge), synchronous active-low reset
//   cmd_valid / cmd_ready    command handshake; cmd_ready is high only in IDLE
//   cmd_write                1 = write burst, 0 = read burst
//   cmd_addr                 start word address
//   cmd_len                  number of beats minus 1
//   wvalid / wready          write beat handshake; wready is high only in WRITE
//   wdata, wstrb             write data and byte enables
//   rvalid, rdata, rlast     read beat output; rdata holds while rvalid is low
//   done, err                one-cycle completion pulse and its error flag
//   busy                     high whenever the block is not IDLE
// -----------------------------------------------------------------------------
module dma_burst_sram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3072,
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic                CK,
    input  logic                RSTN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                rlast,
    output logic                done,
    output logic                err,
    output logic                busy
);

    localparam int NB = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        remain;      // beats left after the current one
    logic              bad;         // current burst started out of range

    logic [DATA_W-1:0] mem [DEPTH];

    logic accept;
    logic beat;
    logic issue;
    logic last_step;
    logic wr_en;

    // Read return pipeline: stage a is one cycle after issue, stage b two.
    logic              a_valid;
    logic              a_last;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_last;
    logic [DATA_W-1:0] b_data;
    logic              out_valid;
    logic              out_last;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign wready    = (state == S_WRITE);
    assign accept    = cmd_valid && cmd_ready;
    assign beat      = wvalid && wready;
    assign issue     = (state == S_READ);
    assign last_step = (remain == 8'd0);
    assign addr_next = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
    // Reset wins over a beat arriving on the same edge.
    assign wr_en     = beat && !bad && RSTN;

    assign out_valid = (RD_LAT == 2) ? b_valid : a_valid;
    assign out_last  = (RD_LAT == 2) ? b_last  : a_last;
    assign rdata     = (RD_LAT == 2) ? b_data  : a_data;
    assign rvalid    = out_valid;
    assign rlast     = out_valid && out_last;

    // Burst control. done/err default low each cycle so they only pulse.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state  <= S_IDLE;
            addr   <= '0;
            remain <= '0;
            bad    <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch below sees the
            // pre-edge values of state, addr and remain.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr   <= cmd_addr;
                        remain <= cmd_len;
                        bad    <= ({1'b0, cmd_addr} >= DEPTH_X);
                        state  <= cmd_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (beat) begin
                        addr   <= addr_next;
                        remain <= remain - 8'd1;
                        if (last_step) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                            err   <= bad;
                        end
                    end
                end
                S_READ: begin
                    addr   <= addr_next;
                    remain <= remain - 8'd1;
                    if (last_step) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rlast) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        err   <= bad;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read return pipeline. Data registers only load on a valid beat so
    // rdata holds its last value between beats; reset clears the in-flight
    // beats and the visible data.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            a_valid <= 1'b0;
            a_last  <= 1'b0;
            a_data  <= '0;
            b_valid <= 1'b0;
            b_last  <= 1'b0;
            b_data  <= '0;
        end else begin
            a_valid <= issue;
            a_last  <= issue && last_step;
            if (issue) begin
                a_data <= bad ? '0 : mem[addr];
            end
            b_valid <= a_valid;
            b_last  <= a_last;
            if (a_valid) begin
                b_data <= a_data;
            end
        end
    end

    // NOTE: the storage array is deliberately left out of reset so that
    // contents survive RSTN and the array can map onto a RAM macro.
    always_ff @(posedge CK) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_burst_sram.sv
// -----------------------------------------------------------------------------
// tb_dma_burst_sram
//
// Drives two instances (RD_LAT = 1 and RD_LAT = 2) with identical command and
// write traffic and checks both against a word-array model of the memory.
// Read expectations come from the model plus the burst timing rules: beat k
// of a read appears k+1+RD_LAT cycles after command acceptance, done one
// cycle after rlast.
// -----------------------------------------------------------------------------
module tb_dma_burst_sram;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 3072;
    localparam int ADDR_W = 12;
    localparam int NB     = DATA_W / 8;

    logic              CK   = 1'b0;
    logic              RSTN = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr  = '0;
    logic [7:0]        cmd_len   = '0;
    logic              wvalid    = 1'b0;
    logic [DATA_W-1:0] wdata     = '0;
    logic [NB-1:0]     wstrb     = '0;

    logic              cmd_ready1, wready1, rvalid1, rlast1, done1, err1, busy1;
    logic [DATA_W-1:0] rdata1;
    logic              cmd_ready2, wready2, rvalid2, rlast2, done2, err2, busy2;
    logic [DATA_W-1:0] rdata2;

    dma_burst_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .CK(CK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wvalid(wvalid), .wready(wready1), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid1), .rdata(rdata1), .rlast(rlast1),
        .done(done1), .err(err1), .busy(busy1)
    );

    dma_burst_sram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
        .CK(CK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wvalid(wvalid), .wready(wready2), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid2), .rdata(rdata2), .rlast(rlast2),
        .done(done2), .err(err2), .busy(busy2)
    );

    always #5 CK = ~CK;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] wb_data [256];
    logic [NB-1:0]     wb_strb [256];
    logic [DATA_W-1:0] rd_exp [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl1"}, {cmd_ready1, wready1, rvalid1, rlast1, done1, err1, busy1}, 7'b1000000);
        check({tag, "_rdata1"}, rdata1, 0);
        check({tag, "_ctrl2"}, {cmd_ready2, wready2, rvalid2, rlast2, done2, err2, busy2}, 7'b1000000);
        check({tag, "_rdata2"}, rdata2, 0);
    endtask

    // Waits (bounded) for both instances to be idle, then presents one
    // command for one cycle. Returns just after the accepting edge.
    task automatic send_cmd(input bit wr, input int a, input int len);
        int w = 0;
        @(negedge CK);
        while (!(cmd_ready1 && cmd_ready2) && w < 50) begin
            @(negedge CK);
            w++;
        end
        check("cmd_ready_wait", {cmd_ready1, cmd_ready2}, 2'b11);
        check("idle_wready", {wready1, wready2}, 2'b00);
        // Junk on the write channel while idle must be ignored.
        wvalid    = 1'($urandom);
        wdata     = $urandom;
        wstrb     = NB'($urandom);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = ADDR_W'(a);
        cmd_len   = 8'(len);
        @(posedge CK);
    endtask

    // Write burst of len+1 beats from wb_data/wb_strb. A forced stall of
    // stall_n cycles is inserted before beat stall_at; rand_stall adds
    // random idle cycles.
    task automatic do_write(input int a, input int len, input int stall_at,
                            input int stall_n, input bit rand_stall);
        int beat = 0;
        int cyc  = 0;
        int left = stall_n;
        bit stall;
        bit bad = (a >= DEPTH);
        send_cmd(1'b1, a, len);
        while (beat <= len && cyc < 4000) begin
            @(negedge CK);
            cyc++;
            cmd_valid = 1'b0;
            check("wr_wready", {wready1, wready2}, 2'b11);
            check("wr_busy", {busy1, busy2}, 2'b11);
            check("wr_done_early", {done1, done2}, 2'b00);
            check("wr_err_without_done", {err1, err2}, 2'b00);
            stall = 1'b0;
            if (beat == stall_at && left > 0) begin
                stall = 1'b1;
                left--;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                stall = 1'b1;
            end
            if (stall) begin
                wvalid = 1'b0;
                wdata  = $urandom;
                wstrb  = NB'($urandom);
            end else begin
                wvalid = 1'b1;
                wdata  = wb_data[beat];
                wstrb  = wb_strb[beat];
                if (!bad) begin
                    for (int i = 0; i < NB; i++) begin
                        if (wb_strb[beat][i]) begin
                            model_mem[(a + beat) % DEPTH][8*i +: 8] = wb_data[beat][8*i +: 8];
                        end
                    end
                end
                beat++;
            end
        end
        check("wr_beats_sent", beat, len + 1);
        @(negedge CK);
        wvalid = 1'b0;
        check("wr_done", {done1, done2}, 2'b11);
        check("wr_err", {err1, err2}, {bad, bad});
        check("wr_busy_after", {busy1, busy2}, 2'b00);
        check("wr_wready_after", {wready1, wready2}, 2'b00);
        @(negedge CK);
        check("wr_done_one_cycle", {done1, done2}, 2'b00);
    endtask

    // Per-cycle read-side checks for one instance.
    task automatic rd_sample(input string who, input int lat, input int c, input int len,
                             input bit bad, input logic rv, input logic rl,
                             input logic [DATA_W-1:0] rd, input logic dn, input logic er,
                             input logic bz, inout int got, inout int dcnt);
        check({who, "_busy"}, bz, c <= len + 1 + lat);
        if (!dn) check({who, "_err_without_done"}, er, 1'b0);
        if (rv) begin
            if (got <= len) begin
                check({who, "_data"}, rd, rd_exp[got]);
                check({who, "_beat_cycle"}, c, got + 1 + lat);
                check({who, "_rlast"}, rl, got == len);
            end else begin
                check({who, "_extra_beat"}, got, len);
            end
            got++;
        end else begin
            check({who, "_rlast_without_rvalid"}, rl, 1'b0);
            if (got > 0 && got <= len + 1) check({who, "_rdata_hold"}, rd, rd_exp[got-1]);
        end
        if (dn) begin
            dcnt++;
            check({who, "_done_cycle"}, c, len + 2 + lat);
            check({who, "_done_err"}, er, bad);
        end
    endtask

    task automatic do_read(input int a, input int len);
        int got1 = 0, got2 = 0, dn1 = 0, dn2 = 0;
        bit bad = (a >= DEPTH);
        rd_exp.delete();
        for (int k = 0; k <= len; k++) begin
            rd_exp.push_back(bad ? '0 : model_mem[(a + k) % DEPTH]);
        end
        send_cmd(1'b0, a, len);
        for (int c = 1; c <= len + 8; c++) begin
            @(negedge CK);
            cmd_valid = 1'b0;
            wvalid    = 1'($urandom);
            wdata     = $urandom;
            wstrb     = NB'($urandom);
            check("rd_wready", {wready1, wready2}, 2'b00);
            rd_sample("rd1", 1, c, len, bad, rvalid1, rlast1, rdata1, done1, err1, busy1, got1, dn1);
            rd_sample("rd2", 2, c, len, bad, rvalid2, rlast2, rdata2, done2, err2, busy2, got2, dn2);
        end
        wvalid = 1'b0;
        check("rd1_beats", got1, len + 1);
        check("rd1_done_count", dn1, 1);
        check("rd2_beats", got2, len + 1);
        check("rd2_done_count", dn2, 1);
    endtask

    task automatic fill_wb(input int len, input bit full_strb);
        for (int k = 0; k <= len; k++) begin
            wb_data[k] = $urandom;
            wb_strb[k] = full_strb ? {NB{1'b1}} : NB'($urandom);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        RSTN = 1'b0;
        repeat (3) @(negedge CK);
        check_idle_outputs("reset");
        RSTN = 1'b1;

        // Fill the whole memory so the model is fully defined.
        for (int i = 0; i < DEPTH / 256; i++) begin
            fill_wb(255, 1'b1);
            do_write(i * 256, 255, -1, 0, 1'b1);
        end

        // Basic burst: A0..A3 at address 5, read back.
        for (int k = 0; k < 4; k++) begin
            wb_data[k] = DATA_W'(32'hA0 + k);
            wb_strb[k] = {NB{1'b1}};
        end
        do_write(5, 3, -1, 0, 1'b0);
        do_read(5, 3);

        // Byte-lane merge: 0x11223344 then 0xAABBCCDD with strobe 0101.
        wb_data[0] = 32'h11223344;
        wb_strb[0] = 4'b1111;
        do_write(0, 0, -1, 0, 1'b0);
        wb_data[0] = 32'hAABBCCDD;
        wb_strb[0] = 4'b0101;
        do_write(0, 0, -1, 0, 1'b0);
        do_read(0, 0);
        check("merge_word", rdata1, 32'h11BB33DD);

        // Address wrap at the top of memory.
        fill_wb(3, 1'b1);
        do_write(DEPTH - 2, 3, -1, 0, 1'b0);
        do_read(DEPTH - 2, 3);

        // Three-cycle stall before the third beat.
        fill_wb(5, 1'b1);
        do_write(100, 5, 2, 3, 1'b0);
        do_read(100, 5);

        // Out-of-range bursts.
        fill_wb(3, 1'b1);
        do_write(DEPTH, 3, -1, 0, 1'b0);
        do_read(DEPTH, 3);
        do_read((1 << ADDR_W) - 1, 1);
        do_read(0, 3);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            int a;
            int len;
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            a   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, (1 << ADDR_W) - 1))
                                              : int'($urandom_range(0, DEPTH - 1));
            fill_wb(len, 1'b0);
            do_write(a, len, -1, 0, 1'b1);
            do_read(a, len);
            do_read(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
        end

        // Reset for one edge during the second read beat of the RD_LAT=1 copy.
        send_cmd(1'b0, 40, 7);
        for (int c = 1; c <= 12; c++) begin
            @(negedge CK);
            cmd_valid = 1'b0;
            wvalid    = 1'b0;
            if (c == 3) begin
                check("rst_mid_second_beat", rvalid1, 1'b1);
                RSTN = 1'b0;
            end else if (c == 4) begin
                check_idle_outputs("rst_mid");
                RSTN = 1'b1;
            end else if (c > 4) begin
                check("rst_no_done", {done1, done2}, 2'b00);
                check("rst_no_rvalid", {rvalid1, rvalid2}, 2'b00);
            end
        end

        // Full scan: contents intact and unaffected by the error bursts.
        for (int i = 0; i < DEPTH / 256; i++) begin
            do_read(i * 256, 255);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
